// File: rtl/dma_controller.sv
// Bus-master DMA engine: copies cmd_len device words into memory at cmd_addr under a BR/BG handshake.
// Optional macro DMA_BURST_RELEASE_EN releases the bus for one GAP cycle every BURST_LEN words.
module dma_controller #(
  parameter int BURST_LEN = 4,
  parameter int LEN_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  input  logic [15:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             br,
  input  logic             bg,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic             mem_ack,
  output logic [LEN_W-1:0] dev_idx,
  input  logic [15:0]      dev_data,
  output logic             busy,
  output logic             irq,
  output logic [2:0]       dbg_state
);

  // Handshakes: a command is taken only when cmd_valid is high in IDLE; a word
  // retires on an edge where mem_we (XFER and bg) and mem_ack are both high.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_XFER = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN + 1) : 1;

  if (BURST_LEN < 1) begin : g_bad_burst
    $error("dma_controller: BURST_LEN must be at least 1");
  end

  state_t           state;
  logic [15:0]      base;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic             retire;

`ifdef DMA_BURST_RELEASE_EN
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
  logic [BW-1:0] bcnt;
`endif

  assign mem_we    = (state == S_XFER) && bg;
  assign retire    = mem_we && mem_ack;
  assign cnt_nxt   = cnt + LEN_W'(1);
  assign mem_addr  = base + 16'(cnt);
  assign dev_idx   = cnt;
  assign mem_wdata = dev_data;
  assign dbg_state = state;

  // br, busy and irq are registered and updated together with each state change.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      base  <= '0;
      len   <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      busy  <= 1'b0;
      irq   <= 1'b0;
`ifdef DMA_BURST_RELEASE_EN
      bcnt  <= '0;
`endif
    end else begin
      irq <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            base <= cmd_addr;
            len  <= cmd_len;
            cnt  <= '0;
            busy <= 1'b1;
`ifdef DMA_BURST_RELEASE_EN
            bcnt <= '0;
`endif
            if (cmd_len == '0) begin
              state <= S_DONE;
              irq   <= 1'b1;
            end else begin
              state <= S_REQ;
              br    <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (bg) state <= S_XFER;
        end
        S_XFER: begin
          if (retire) begin
            cnt <= cnt_nxt;
            if (cnt_nxt == len) begin
              state <= S_DONE;
              br    <= 1'b0;
              irq   <= 1'b1;
            end
`ifdef DMA_BURST_RELEASE_EN
            else if (bcnt == BURST_LAST) begin
              state <= S_GAP;
              br    <= 1'b0;
              bcnt  <= '0;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
`endif
          end else if (!bg) begin
            // Grant withdrawn: keep counters, re-issue the pending word after regrant.
            state <= S_REQ;
          end
        end
        S_GAP: begin
          state <= S_REQ;
          br    <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          br    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: scoreboarded memory writes plus handshake timing checks.
module tb_dma_controller;
  localparam int LEN_W = 8;
`ifdef DMA_BURST_RELEASE_EN
  localparam int EXP_GAPS = 2;
`else
  localparam int EXP_GAPS = 0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cmd_valid;
  logic [15:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             br;
  logic             bg;
  logic             mem_we;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_wdata;
  logic             mem_ack;
  logic [LEN_W-1:0] dev_idx;
  logic [15:0]      dev_data;
  logic             busy;
  logic             irq;
  logic [2:0]       dbg_state;

  // clock / device model
  always #5 clk = ~clk;
  assign dev_data = {dev_idx, ~dev_idx};

  dma_controller #(.BURST_LEN(4), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .br(br), .bg(bg), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .dev_idx(dev_idx), .dev_data(dev_data),
    .busy(busy), .irq(irq), .dbg_state(dbg_state)
  );

  int vectors = 0;
  int errors = 0;
  int wr_cnt = 0;
  int irq_cnt = 0;
  int gap_cnt = 0;
  int ack_ctr = 0;
  int bg_hold = 0;
  bit bg_auto = 1'b0;
  bit ack_mode = 1'b0;
  bit br_seen = 1'b0;
  bit hold_pend = 1'b0;
  logic s_br, s_we, s_busy, s_irq;
  logic [15:0] s_addr, hold_addr, hold_data;
  logic [LEN_W-1:0] s_idx;
  logic [31:0] exp_q[$];

  function automatic logic [15:0] dev_word(input logic [7:0] i);
    return {i, ~i};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, scoreboard writes, then drive inputs just after posedge.
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    s_br = br; s_we = mem_we; s_busy = busy; s_irq = irq;
    s_addr = mem_addr; s_idx = dev_idx;
    if (br) br_seen = 1'b1;
    if (irq) irq_cnt++;
    if (busy && !br && !irq) gap_cnt++;
    if (reset_n && mem_we) begin
      if (hold_pend) begin
        chk("hold_addr", mem_addr, hold_addr);
        chk("hold_data", mem_wdata, hold_data);
      end
      hold_pend = !mem_ack;
      hold_addr = mem_addr;
      hold_data = mem_wdata;
      if (mem_ack) begin
        wr_cnt++;
        chk("sb_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("write", {mem_addr, mem_wdata}, e);
        end
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (bg_hold > 0) begin
      bg = 1'b0;
      bg_hold--;
    end else if (bg_auto) begin
      bg = s_br;
    end
    if (ack_mode) begin
      ack_ctr++;
      mem_ack = (ack_ctr % 3 == 0);
    end
  endtask

  task automatic send_cmd(input logic [15:0] a, input logic [LEN_W-1:0] l);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    step();
  endtask

  task automatic push_words(input logic [15:0] a, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({a + 16'(i), dev_word(8'(i))});
  endtask

  task automatic wait_irq(input string tag, input int budget);
    int start;
    start = irq_cnt;
    for (int i = 0; i < budget && irq_cnt == start; i++) step();
    chk({tag, "_irq_seen"}, irq_cnt - start, 1);
  endtask

  task automatic wait_words(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && wr_cnt < target; i++) step();
    chk({tag, "_reached"}, wr_cnt >= target, 1);
  endtask

  initial begin
    int w0, i0;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    bg = 1'b0; mem_ack = 1'b1;

    // reset state
    step(); step();
    chk("reset_br", s_br, 0);
    chk("reset_we", s_we, 0);
    chk("reset_busy", s_busy, 0);
    chk("reset_irq", s_irq, 0);
    chk("reset_addr", s_addr, 0);
    chk("reset_idx", s_idx, 0);
    chk("reset_state", dbg_state, 0);
    reset_n = 1'b1;
    step();

    // basic 12-word transfer, bg follows br by one cycle
    bg_auto = 1'b1; gap_cnt = 0; w0 = wr_cnt; i0 = irq_cnt;
    push_words(16'h0100, 12);
    send_cmd(16'h0100, 12);
    step();
    chk("basic_cmd_br", s_br, 1);
    chk("basic_cmd_busy", s_busy, 1);
    wait_irq("basic", 200);
    step(); step(); step();
    chk("basic_sb_empty", exp_q.size(), 0);
    chk("basic_words", wr_cnt - w0, 12);
    chk("basic_gaps", gap_cnt, EXP_GAPS);
    chk("basic_irq_once", irq_cnt - i0, 1);
    chk("basic_busy_low", s_busy, 0);

    // grant withdrawn for 3 cycles while word 6 is pending
    gap_cnt = 0; w0 = wr_cnt; i0 = irq_cnt;
    push_words(16'h0100, 12);
    send_cmd(16'h0100, 12);
    wait_words("wd_w5", w0 + 5, 200);
    bg = 1'b0;
    #1;
    chk("wd_we_drop", mem_we, 0);
    chk("wd_br_held", br, 1);
    chk("wd_idx", dev_idx, 5);
    bg_hold = 2;
    wait_irq("wd", 200);
    step(); step();
    chk("wd_sb_empty", exp_q.size(), 0);
    chk("wd_words", wr_cnt - w0, 12);
    chk("wd_gaps", gap_cnt, EXP_GAPS);
    chk("wd_irq_once", irq_cnt - i0, 1);

    // memory wait states: ack every third cycle
    w0 = wr_cnt; hold_pend = 1'b0;
    ack_mode = 1'b1; ack_ctr = 0; mem_ack = 1'b0;
    push_words(16'h0500, 5);
    send_cmd(16'h0500, 5);
    wait_irq("ws", 300);
    ack_mode = 1'b0; mem_ack = 1'b1; hold_pend = 1'b0;
    step(); step();
    chk("ws_sb_empty", exp_q.size(), 0);
    chk("ws_words", wr_cnt - w0, 5);

    // address wrap with grant already held: 1 REQ + 4 XFER, then DONE
    bg_auto = 1'b0; bg = 1'b1; w0 = wr_cnt;
    push_words(16'hFFFE, 4);
    send_cmd(16'hFFFE, 4);
    step();
    chk("wrap_req_we", s_we, 0);
    step(); step(); step(); step();
    chk("wrap_no_irq_yet", s_irq, 0);
    step();
    chk("wrap_irq_latency", s_irq, 1);
    chk("wrap_irq_br_low", s_br, 0);
    step();
    chk("wrap_irq_pulse", s_irq, 0);
    chk("wrap_sb_empty", exp_q.size(), 0);
    chk("wrap_words", wr_cnt - w0, 4);

    // zero length
    bg = 1'b0; br_seen = 1'b0;
    send_cmd(16'h0700, 0);
    step();
    chk("zl_irq", s_irq, 1);
    chk("zl_br", s_br, 0);
    chk("zl_busy", s_busy, 1);
    step();
    chk("zl_irq_off", s_irq, 0);
    chk("zl_busy_off", s_busy, 0);
    step();
    chk("zl_br_never", br_seen, 0);

    // ignored mid-transfer command, then reset at word 3
    bg_auto = 1'b1; w0 = wr_cnt; i0 = irq_cnt;
    push_words(16'h0300, 8);
    send_cmd(16'h0300, 8);
    wait_words("ign_w1", w0 + 1, 100);
    cmd_valid = 1'b1; cmd_addr = 16'h0200; cmd_len = 2;
    step();
    wait_words("ign_w2", w0 + 2, 100);
    chk("ign_addr", mem_addr, 16'h0302);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk("rst_br", s_br, 0);
    chk("rst_we", s_we, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_irq", s_irq, 0);
    chk("rst_words", wr_cnt - w0, 2);
    step();
    chk("rst_no_irq", irq_cnt - i0, 0);
    exp_q.delete();

    // clean restart after reset
    w0 = wr_cnt; i0 = irq_cnt;
    push_words(16'h0400, 3);
    send_cmd(16'h0400, 3);
    wait_irq("restart", 100);
    step(); step();
    chk("restart_sb_empty", exp_q.size(), 0);
    chk("restart_words", wr_cnt - w0, 3);
    chk("restart_irq_once", irq_cnt - i0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/dma_controller.md
# dma_controller

Bus-master DMA engine for the pipelined 16-bit CPU. It takes a transfer command from the CPU and arbitrates for the memory bus with a BR/BG handshake. Once granted, it copies words from an external device buffer into data memory in bursts, then signals completion with a one-cycle interrupt. While the CPU holds the bus, the engine is parked. While the engine holds the bus, the CPU stalls its memory stage.

## Interface
- `BURST_LEN`, default 4: words written per bus tenure. Must be ≥1.
- `LEN_W`, default 8: width of the length field and the word counter.

Clock, reset and ports:
- `clk`: input, 1 bit. The single clock.
- `reset_n`: input, 1 bit. Synchronous, active-low reset.
- `cmd_valid`: input, 1 bit. Single-cycle command strobe from the CPU.
- `cmd_addr`: input, 16 bits. Base memory word address.
- `cmd_len`: input, `LEN_W` bits. Number of words to transfer.
- `br`: output, 1 bit. Bus request to the CPU.
- `bg`: input, 1 bit. Bus grant from the CPU.
- `mem_we`: output, 1 bit. Memory write strobe.
- `mem_addr`: output, 16 bits. Memory write address.
- `mem_wdata`: output, 16 bits. Memory write data, equal to `dev_data`.
- `mem_ack`: input, 1 bit. Memory accepted the write this cycle.
- `dev_idx`: output, `LEN_W` bits. Index of the word currently requested from the device.
- `dev_data`: input, 16 bits. Device word at `dev_idx`, combinational from `dev_idx`.
- `busy`: output, 1 bit. High from command acceptance until `irq`.
- `irq`: output, 1 bit. Transfer-complete pulse.

## Operation
- FSM states: IDLE, REQ, XFER, GAP, DONE. The encoding is a local choice.
- IDLE
  - `cmd_valid`=1 latches `cmd_addr` and `cmd_len`, clears the word counter `cnt` and the burst counter `bcnt`, and sets `busy`.
  - Goes to REQ, or straight to DONE if `cmd_len`=0.
- REQ: `br`=1. Moves to XFER on the first edge where `bg`=1.
- XFER
  - `br`=1, and `mem_we` = `bg` (combinational).
  - `mem_addr` = base + `cnt`, modulo 2^16: the address wraps and the wrap is not an error.
  - `dev_idx` = `cnt`.
  - A word retires on each edge with `mem_we` & `mem_ack`; that edge increments `cnt` and `bcnt`.
  - After the retiring edge:
    - If `cnt` reaches the latched length, go to DONE.
    - Otherwise, if `bcnt` reaches `BURST_LEN`, go to GAP and clear `bcnt`.
    - Otherwise, stay in XFER.
- XFER, grant withdrawn: if `bg` drops, `mem_we` falls the same cycle and nothing retires. The FSM returns to REQ with `cnt` and `bcnt` kept, and the pending word is re-issued after the next grant.
- GAP: `br`=0 for exactly one cycle so the CPU can take the bus, then REQ.
- DONE: `irq`=1 and `br`=0 for one cycle. `busy` clears on the same edge the FSM returns to IDLE.
- `cmd_valid` outside IDLE is ignored and has no side effects.
- `mem_wdata` always equals `dev_data`. It is only meaningful while `mem_we`=1.

## Timing
- Reset, with `reset_n`=0 at an edge:
  - FSM goes to IDLE.
  - `br`, `mem_we`, `busy`, `irq` = 0.
  - `mem_addr`, `dev_idx` = 0 and counters = 0.
- Reset mid-transfer aborts immediately with no `irq`. Words already written stay in memory.
- Command to request: `cmd_valid` sampled at edge N gives `br`=1 and `busy`=1 during cycle N+1.
- Grant to write: `bg`=1 sampled at edge M puts the FSM in XFER, with `mem_we`=1 in cycle M+1 if `bg` is still high.
- Throughput: one word per cycle while `mem_ack` is held high. Memory wait states are absorbed by holding `mem_we`, address and data stable.
- Zero-stall burst of `BURST_LEN` words:
  - If the grant is already held in REQ, the burst takes `BURST_LEN` XFER cycles plus 1 REQ cycle.
  - The GAP adds 1 cycle between bursts.
- Completion: `irq` rises in the cycle after the final retiring edge, stays high exactly 1 cycle, and is coincident with `br`=0.
- `cmd_len`=0: DONE in cycle N+1 and `irq` for 1 cycle. `br` never rises.

## Configuration
- Macro: `DMA_BURST_RELEASE_EN`.
- Defined: behaviour exactly as above. The bus is released through GAP every `BURST_LEN` words.
- Undefined:
  - GAP is never entered and `bcnt` is unused.
  - `br` stays high from REQ until DONE, so the whole transfer is a single tenure.
  - Grant-withdrawal handling in XFER is unchanged.

## Test plan
- Basic transfer: reset, then `cmd_addr`=0x0100, `cmd_len`=12, `bg` follows `br` after 1 cycle, `mem_ack`=1.
  - 12 writes to 0x0100–0x010B with data `dev_data[i]`.
  - With the macro, `br` is low for 1 cycle after words 4 and 8.
  - Exactly one `irq`, and `busy` low afterwards.
- Grant withdrawal: as above, but drop `bg` for 3 cycles while word 6 is pending.
  - `mem_we` falls the same cycle.
  - Word 6 is written exactly once after regrant, and there are no duplicate or skipped addresses.
- Memory wait states: `mem_ack` high only every third cycle, with `cmd_len`=5.
  - `mem_addr` and `mem_wdata` are held stable until ack.
  - 5 writes, then `irq`.
- Address wrap and zero length:
  - `cmd_addr`=0xFFFE, `cmd_len`=4 writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - `cmd_len`=0 produces `irq` in cycle N+1 with `br` never asserted.
- Ignored command and reset: a `cmd_valid` with `cmd_addr`=0x0200 issued mid-transfer does not change the addresses in use.
  - `reset_n`=0 at word 3: next cycle `br`, `mem_we`, `busy` = 0, and no `irq`.
  - A new command after reset starts cleanly.
- Macro undefined, `cmd_len`=12: `br` is continuously high for the whole transfer, with no GAP cycles.
